// File: rtl/mips_pkg.sv
// Shared constants for the five-stage MIPS core: load types, write-data
// sources and the store types used by the data memory.
package mips_pkg;

  // Load-type encodings; 3'b101..3'b111 are handled as word loads
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW  = 3'b100;

  // Write-back data source selection
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC8 = 2'd2;

  // Store-type encodings consumed by the data memory
  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b011;

endpackage

// File: rtl/load_ext.sv
// Combinational load-data extraction: picks the addressed byte/half/word out
// of the memory word, extends it, and reports a raw misalignment condition.
// The caller qualifies the misalignment flag with "this is really a load".
module load_ext
  import mips_pkg::*;
#(
  parameter int LDTYPE_W = 3
) (
  input  logic [31:0]         word,
  input  logic [1:0]          addr,
  input  logic [LDTYPE_W-1:0] ld_type,
  output logic [31:0]         value,
  output logic                misalign
);

  logic [2:0]  lt_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign lt_s = ld_type[2:0];

  // Select the addressed byte and half-word lanes of the memory word
  always_comb begin
    byte_s = 8'h00;
    case (addr)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extend the selected lane by load type; unknown encodings behave as LW
  always_comb begin
    value    = 32'h0000_0000;
    misalign = 1'b0;
    case (lt_s)
      LT_LB: begin
        value    = {{24{byte_s[7]}}, byte_s};
        misalign = 1'b0;
      end
      LT_LBU: begin
        value    = {24'h00_0000, byte_s};
        misalign = 1'b0;
      end
      LT_LH: begin
        value    = {{16{half_s[15]}}, half_s};
        misalign = addr[0];
      end
      LT_LHU: begin
        value    = {16'h0000, half_s};
        misalign = addr[0];
      end
      default: begin
        value    = word;
        misalign = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_ldext.sv
// MEM/WB pipeline register with load extraction. Captures the MEM-stage
// results, then in WB produces the final register-file write data (also used
// by the forwarding network) and a misaligned-load flag that suppresses the
// register write.
module mem_wb_ldext
  import mips_pkg::*;
#(
  parameter int LDTYPE_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                flush,
  input  logic [31:0]         PC4_M,
  input  logic [31:0]         DMOut_M,
  input  logic [31:0]         ALUOut_M,
  input  logic [LDTYPE_W-1:0] LoadType_M,
  input  logic [1:0]          WDSel_M,
  input  logic                RegWrite_M,
  input  logic [4:0]          A3_M,
  output logic [31:0]         PC4_W,
  output logic [4:0]          A3_W,
  output logic                RegWrite_W,
  output logic [31:0]         WD_W,
  output logic                AdEL_W
);

  logic [31:0]         pc4_r;
  logic [31:0]         dmout_r;
  logic [31:0]         aluout_r;
  logic [LDTYPE_W-1:0] ldtype_r;
  logic [1:0]          wdsel_r;
  logic                regwrite_r;
  logic [4:0]          a3_r;

  logic [31:0]         ld_value_s;
  logic                ld_misalign_s;
  logic                adel_s;
  logic [31:0]         wd_s;

  // Pipeline register: reset, then flush (bubble, wins over stall), then load
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc4_r      <= 32'h0000_0000;
      dmout_r    <= 32'h0000_0000;
      aluout_r   <= 32'h0000_0000;
      ldtype_r   <= {LDTYPE_W{1'b0}};
      wdsel_r    <= 2'd0;
      regwrite_r <= 1'b0;
      a3_r       <= 5'd0;
    end else if (en) begin
      pc4_r      <= PC4_M;
      dmout_r    <= DMOut_M;
      aluout_r   <= ALUOut_M;
      ldtype_r   <= LoadType_M;
      wdsel_r    <= WDSel_M;
      regwrite_r <= RegWrite_M;
      a3_r       <= A3_M;
    end else begin
      pc4_r      <= pc4_r;
      dmout_r    <= dmout_r;
      aluout_r   <= aluout_r;
      ldtype_r   <= ldtype_r;
      wdsel_r    <= wdsel_r;
      regwrite_r <= regwrite_r;
      a3_r       <= a3_r;
    end
  end

  load_ext #(
    .LDTYPE_W (LDTYPE_W)
  ) u_load_ext (
    .word     (dmout_r),
    .addr     (aluout_r[1:0]),
    .ld_type  (ldtype_r),
    .value    (ld_value_s),
    .misalign (ld_misalign_s)
  );

  // Write-data source mux; PC+8 is the registered PC+4 plus 4, wrapping
  always_comb begin
    wd_s = 32'h0000_0000;
    case (wdsel_r)
      WD_ALU:  wd_s = aluout_r;
      WD_MEM:  wd_s = ld_value_s;
      WD_PC8:  wd_s = pc4_r + 32'd4;
      default: wd_s = 32'h0000_0000;
    endcase
  end

  // Misalignment only matters when the instruction actually writes back memory data
  assign adel_s = (wdsel_r == WD_MEM) && ld_misalign_s;

  assign PC4_W      = pc4_r;
  assign A3_W       = a3_r;
  assign WD_W       = wd_s;
  assign AdEL_W     = adel_s;
  assign RegWrite_W = regwrite_r && (a3_r != 5'd0) && !adel_s;

endmodule

// File: tb/tb_mem_wb_ldext.sv
// Self-checking bench for mem_wb_ldext: directed cases plus randomized
// traffic against a behavioural model of the pipeline register and load rules.
module tb_mem_wb_ldext;

  logic        clk = 1'b0;
  logic        reset = 1'b0, en = 1'b0, flush = 1'b0;
  logic [31:0] PC4_M = 32'h0, DMOut_M = 32'h0, ALUOut_M = 32'h0;
  logic [2:0]  LoadType_M = 3'd0;
  logic [1:0]  WDSel_M = 2'd0;
  logic        RegWrite_M = 1'b0;
  logic [4:0]  A3_M = 5'd0;
  logic [31:0] PC4_W, WD_W;
  logic [4:0]  A3_W;
  logic        RegWrite_W, AdEL_W;

  int tests = 0;
  int fails = 0;

  // model of captured fields
  logic [31:0] m_pc4 = 32'h0, m_dm = 32'h0, m_alu = 32'h0;
  logic [2:0]  m_lt = 3'd0;
  logic [1:0]  m_wds = 2'd0;
  logic        m_rw = 1'b0;
  logic [4:0]  m_a3 = 5'd0;

  mem_wb_ldext #(.LDTYPE_W(3)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .PC4_M(PC4_M), .DMOut_M(DMOut_M), .ALUOut_M(ALUOut_M),
    .LoadType_M(LoadType_M), .WDSel_M(WDSel_M), .RegWrite_M(RegWrite_M),
    .A3_M(A3_M), .PC4_W(PC4_W), .A3_W(A3_W), .RegWrite_W(RegWrite_W),
    .WD_W(WD_W), .AdEL_W(AdEL_W)
  );

  always #5 clk = ~clk;

  function automatic logic [70:0] dut_vec();
    return {PC4_W, A3_W, RegWrite_W, WD_W, AdEL_W};
  endfunction

  // Expected outputs computed from the model's captured fields
  function automatic logic [70:0] model_out();
    logic [31:0] a, b, h, ld, wd;
    logic mis, adel, rw;
    a = m_alu % 32'd4;
    b = (m_dm >> (32'd8 * a)) & 32'hFF;
    h = (a >= 32'd2) ? (m_dm >> 16) : (m_dm & 32'hFFFF);
    mis = 1'b0;
    case (m_lt)
      3'd0: ld = (b >= 32'd128) ? b - 32'd256 : b;
      3'd1: ld = b;
      3'd2: begin ld = (h >= 32'd32768) ? h - 32'd65536 : h; mis = (a % 32'd2) == 32'd1; end
      3'd3: begin ld = h; mis = (a % 32'd2) == 32'd1; end
      default: begin ld = m_dm; mis = (a != 32'd0); end
    endcase
    adel = (m_wds == 2'd1) && mis;
    case (m_wds)
      2'd0: wd = m_alu;
      2'd1: wd = ld;
      2'd2: wd = m_pc4 + 32'd4;
      default: wd = 32'd0;
    endcase
    rw = m_rw && (m_a3 != 5'd0) && !adel;
    return {m_pc4, m_a3, rw, wd, adel};
  endfunction

  // One clock edge: update the model with the priority rules, then settle
  task automatic tick();
    if (reset || flush) begin
      m_pc4 = 32'h0; m_dm = 32'h0; m_alu = 32'h0; m_lt = 3'd0;
      m_wds = 2'd0; m_rw = 1'b0; m_a3 = 5'd0;
    end else if (en) begin
      m_pc4 = PC4_M; m_dm = DMOut_M; m_alu = ALUOut_M; m_lt = LoadType_M;
      m_wds = WDSel_M; m_rw = RegWrite_M; m_a3 = A3_M;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc4, input logic [31:0] dm, input logic [31:0] alu,
                       input logic [2:0] lt, input logic [1:0] wds, input logic rw, input logic [4:0] a3);
    PC4_M = pc4; DMOut_M = dm; ALUOut_M = alu; LoadType_M = lt;
    WDSel_M = wds; RegWrite_M = rw; A3_M = a3;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1;
    drive(32'h1234, 32'h5678, 32'h9ABC, 3'd4, 2'd2, 1'b1, 5'd9);
    tick();
    tests++;
    if (dut_vec() !== 71'h0) begin
      fails++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), 71'h0);
    end
    reset = 1'b0;
  endtask

  task automatic test_byte_loads();
    en = 1'b1;
    drive(32'h100, 32'h8899AABB, 32'h2001, 3'd0, 2'd1, 1'b1, 5'd5);
    tick();
    tests++;
    if (WD_W !== 32'hFFFFFFAA) begin fails++; $display("FAIL lb_wd got=%h exp=%h", WD_W, 32'hFFFFFFAA); end
    tests++;
    if (dut_vec() !== model_out()) begin fails++; $display("FAIL lb_all got=%h exp=%h", dut_vec(), model_out()); end
    LoadType_M = 3'd1;
    tick();
    tests++;
    if (WD_W !== 32'h000000AA) begin fails++; $display("FAIL lbu_wd got=%h exp=%h", WD_W, 32'h000000AA); end
  endtask

  task automatic test_half_loads();
    en = 1'b1;
    drive(32'h104, 32'h8001FFFF, 32'h2002, 3'd2, 2'd1, 1'b1, 5'd6);
    tick();
    tests++;
    if (WD_W !== 32'hFFFF8001) begin fails++; $display("FAIL lh_wd got=%h exp=%h", WD_W, 32'hFFFF8001); end
    LoadType_M = 3'd3;
    tick();
    tests++;
    if (WD_W !== 32'h00008001) begin fails++; $display("FAIL lhu_wd got=%h exp=%h", WD_W, 32'h00008001); end
  endtask

  task automatic test_misalign();
    en = 1'b1;
    drive(32'h108, 32'hCAFEF00D, 32'h2000, 3'd4, 2'd1, 1'b1, 5'd7);
    tick();
    tests++;
    if ({AdEL_W, RegWrite_W, WD_W} !== {1'b0, 1'b1, 32'hCAFEF00D}) begin
      fails++; $display("FAIL lw_aligned got=%b%b_%h exp=01_cafef00d", AdEL_W, RegWrite_W, WD_W);
    end
    ALUOut_M = 32'h2002;
    tick();
    tests++;
    if ({AdEL_W, RegWrite_W, A3_W} !== {1'b1, 1'b0, 5'd7}) begin
      fails++; $display("FAIL lw_misaligned got=%b%b_%0d exp=10_7", AdEL_W, RegWrite_W, A3_W);
    end
    LoadType_M = 3'd2; ALUOut_M = 32'h2003;
    tick();
    tests++;
    if (AdEL_W !== 1'b1) begin fails++; $display("FAIL lh_misaligned got=%b exp=1", AdEL_W); end
    LoadType_M = 3'd6; ALUOut_M = 32'h2001;
    tick();
    tests++;
    if (AdEL_W !== 1'b1) begin fails++; $display("FAIL lw_alias_misaligned got=%b exp=1", AdEL_W); end
    WDSel_M = 2'd0;
    tick();
    tests++;
    if ({AdEL_W, RegWrite_W, WD_W} !== {1'b0, 1'b1, 32'h2001}) begin
      fails++; $display("FAIL alu_no_adel got=%b%b_%h exp=01_00002001", AdEL_W, RegWrite_W, WD_W);
    end
  endtask

  task automatic test_pc8();
    en = 1'b1;
    drive(32'h00003008, 32'h0, 32'h0, 3'd0, 2'd2, 1'b1, 5'd31);
    tick();
    tests++;
    if ({WD_W, RegWrite_W} !== {32'h0000300C, 1'b1}) begin
      fails++; $display("FAIL pc8_wd got=%h_%b exp=0000300c_1", WD_W, RegWrite_W);
    end
    A3_M = 5'd0;
    tick();
    tests++;
    if (RegWrite_W !== 1'b0) begin fails++; $display("FAIL a3_zero_rw got=%b exp=0", RegWrite_W); end
    PC4_M = 32'hFFFFFFFC; A3_M = 5'd3;
    tick();
    tests++;
    if (WD_W !== 32'h0) begin fails++; $display("FAIL pc8_wrap got=%h exp=00000000", WD_W); end
    WDSel_M = 2'd3; ALUOut_M = 32'h55;
    tick();
    tests++;
    if (WD_W !== 32'h0) begin fails++; $display("FAIL wdsel3 got=%h exp=00000000", WD_W); end
  endtask

  task automatic test_stall();
    logic [70:0] held;
    en = 1'b1;
    drive(32'h400, 32'h11223344, 32'h3001, 3'd0, 2'd1, 1'b1, 5'd12);
    tick();
    held = {32'h400, 5'd12, 1'b1, 32'h00000033, 1'b0};
    tests++;
    if (dut_vec() !== held) begin fails++; $display("FAIL stall_load got=%h exp=%h", dut_vec(), held); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, 3'($urandom), 2'($urandom), 1'b1, 5'($urandom));
      tick();
      tests++;
      if (dut_vec() !== held) begin fails++; $display("FAIL stall_hold%0d got=%h exp=%h", i, dut_vec(), held); end
    end
    en = 1'b1;
    drive(32'h500, 32'hA0B0C0D0, 32'h0000000C, 3'd4, 2'd1, 1'b1, 5'd13);
    tick();
    tests++;
    if (dut_vec() !== {32'h500, 5'd13, 1'b1, 32'hA0B0C0D0, 1'b0}) begin
      fails++; $display("FAIL stall_release got=%h exp=%h", dut_vec(), {32'h500, 5'd13, 1'b1, 32'hA0B0C0D0, 1'b0});
    end
  endtask

  task automatic test_flush();
    en = 1'b0; flush = 1'b1;
    tick();
    tests++;
    if (dut_vec() !== 71'h0) begin fails++; $display("FAIL flush_stall got=%h exp=0", dut_vec()); end
    flush = 1'b0; en = 1'b1;
    drive(32'h600, 32'h1, 32'h4, 3'd4, 2'd0, 1'b1, 5'd2);
    tick();
    en = 1'b0;
    tick();
    reset = 1'b1; flush = 1'b1;
    tick();
    tests++;
    if (dut_vec() !== 71'h0) begin fails++; $display("FAIL reset_flush got=%h exp=0", dut_vec()); end
    reset = 1'b0; flush = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 29) == 0);
      flush = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      drive($urandom, $urandom, $urandom, 3'($urandom), 2'($urandom),
            1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      tick();
      tests++;
      if (dut_vec() !== model_out()) begin
        fails++; $display("FAIL random%0d got=%h exp=%h", i, dut_vec(), model_out());
      end
    end
    reset = 1'b0; flush = 1'b0; en = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_byte_loads();
    test_half_loads();
    test_misalign();
    test_pc8();
    test_stall();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_ldext.md
# mem_wb_ldext

MEM/WB pipeline register with load-data extraction for the five-stage MIPS core. It sits directly downstream of the data memory. It captures the memory read word, the ALU address, the PC and the write-back control at the end of MEM. In WB it produces the aligned, sign- or zero-extended load value, selects the final register-file write data, and flags misaligned loads. The same write-data output also feeds the forwarding network in D/E.

## Interface
Parameters:
- `LDTYPE_W`, default 3: width of the load-type field.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `en` in 1: when 1, the register captures inputs; when 0, it holds (stall).
- `flush` in 1: inserts a bubble at the next edge.
- `PC4_M` in 32: PC+4 of the instruction in MEM.
- `DMOut_M` in 32: word read from data memory at `ALUOut_M[13:2]`.
- `ALUOut_M` in 32: ALU result or memory byte address.
- `LoadType_M` in 3: load encoding, defined in the package.
- `WDSel_M` in 2: write-data source; 0 = ALU, 1 = memory, 2 = PC+8.
- `RegWrite_M` in 1: register-file write enable.
- `A3_M` in 5: destination register.
- `PC4_W` out 32: registered PC+4.
- `A3_W` out 5: registered destination register.
- `RegWrite_W` out 1: effective register-file write enable.
- `WD_W` out 32: final write-back data.
- `AdEL_W` out 1: misaligned-load flag.

## Operation
- Registered fields: PC4, DMOut, ALUOut, LoadType, WDSel, RegWrite, A3.
- Update priority at each edge:
  - `reset` clears all fields to 0.
  - Otherwise `flush` clears all fields to 0 (bubble). `flush` overrides `en=0`.
  - Otherwise `en=1` loads the `_M` inputs.
  - Otherwise all fields hold.
- Load extraction uses the registered `addr = ALUOut[1:0]` and the registered DMOut:
  - LB / LBU: selected byte is `DMOut[8*addr+7 : 8*addr]`. LB sign-extends it; LBU zero-extends it.
  - LH / LHU: selected half is `DMOut[15:0]` when `addr[1]=0`, else `DMOut[31:16]`. LH sign-extends it; LHU zero-extends it.
  - LW: `DMOut` unchanged.
  - Encodings 101–111 are treated as LW.
- Write-data selection:
  - `WD_W` = ALUOut when WDSel=0.
  - `WD_W` = extracted load value when WDSel=1.
  - `WD_W` = PC4 + 4 when WDSel=2.
  - `WD_W` = 0 when WDSel=3.
- Misalignment: `AdEL_W` = 1 when WDSel=1 and either of the following holds:
  - the load is LH/LHU and `addr[0]=1`;
  - the load is LW (or an LW-equivalent encoding) and `addr != 0`.
- `RegWrite_W` = RegWrite AND (A3 != 0) AND NOT `AdEL_W`.
- `A3_W` is always the registered value, even when `RegWrite_W` is forced to 0.
- All arithmetic is 32-bit and wraps modulo 2^32; PC4 + 4 at 0xFFFFFFFC gives 0x00000000.

## Timing
- Latency is 1 cycle: `_M` inputs sampled at edge N appear, extracted, on the `_W` outputs after edge N.
- Outputs are combinational from registers only. There is no input-to-output combinational path.
- Reset values (after a reset edge): PC4_W=0, A3_W=0, RegWrite_W=0, WD_W=0 (WDSel=0, ALUOut=0), AdEL_W=0.
- Stall: while `en=0` and `flush=0`, every output stays stable for any number of cycles.
- Reset asserted mid-stall or together with `flush` clears all state at that edge.
- Releasing `en` after a stall loads the values present on the `_M` inputs at that edge; captured values are never dropped or duplicated.

## Structure
- Shared package `mips_pkg` holds:
  - load-type constants: LB=000, LBU=001, LH=010, LHU=011, LW=100;
  - WDSel constants: ALU=0, MEM=1, PC8=2;
  - store-type constants: SB=000, SH=001, SW=011, which are already in use by DM.
- One sub-module, `load_ext`: purely combinational. Inputs are the word, addr[1:0] and load type; outputs are the extracted value and the misalignment flag. It is instantiated once on the registered fields.
- The top level contains the pipeline register, update-priority logic, write-data mux and `RegWrite_W` gating.

## Test plan
- Reset cycle, then one edge with `en=1` and LB/WDSel=1, DMOut_M=0x8899AABB, ALUOut_M=0x2001 -> WD_W=0xFFFFFFAA one cycle later. LBU with the same inputs -> 0x000000AA.
- LH at addr 0x2002 with DMOut_M=0x8001FFFF -> WD_W=0xFFFF8001. LHU at the same address -> 0x00008001.
- LW at addr 0x2002 -> AdEL_W=1, RegWrite_W=0, A3_W unchanged. LH at 0x2003 -> AdEL_W=1.
- WDSel=2 with PC4_M=0x00003008, A3_M=31 -> WD_W=0x0000300C, RegWrite_W=1. A3_M=0 with RegWrite_M=1 -> RegWrite_W=0.
- Load value X, then hold `en=0` for 3 cycles while the inputs change -> outputs keep X. Next edge with `en=1` -> outputs show the new inputs.
- `flush=1` with `en=0` -> all outputs 0 next cycle. `reset=1` and `flush=1` together mid-stall -> all outputs 0.
